// File: rtl/sys_defs.sv
// Shared load-path definitions: machine width, memory-size codes and the result entry layout.
`ifndef XLEN
`define XLEN 32
`endif

package sys_defs;

  localparam int unsigned XLEN      = `XLEN;
  // Widest destination tag an entry can carry; narrower tags are zero-padded.
  localparam int unsigned TAG_W_MAX = 16;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;
  localparam logic [1:0] MEM_RSVD = 2'b11;

  typedef struct packed {
    logic [XLEN-1:0]      value;
    logic [TAG_W_MAX-1:0] tag;
    logic                 err;
  } lrb_entry_t;

endpackage

// File: rtl/load_align.sv
// Picks the addressed bytes out of a cache doubleword and sign/zero-extends them.
module load_align
  import sys_defs::*;
(
  input  logic [63:0]     load_data,
  input  logic [2:0]      addr_lo,
  input  logic [2:0]      mem_size,
  output logic [XLEN-1:0] value_c,
  output logic            err_c
);

  logic [31:0] shifted;

  always_comb begin
    shifted = 32'(load_data >> {addr_lo, 3'b000});
    value_c = '0;
    err_c   = 1'b0;
    case (mem_size[1:0])
      MEM_BYTE: value_c = mem_size[2] ? XLEN'(shifted[7:0])
                                      : XLEN'({{24{shifted[7]}}, shifted[7:0]});
      MEM_HALF: begin
        if (addr_lo[0]) err_c = 1'b1;
        else value_c = mem_size[2] ? XLEN'(shifted[15:0])
                                   : XLEN'({{16{shifted[15]}}, shifted[15:0]});
      end
      MEM_WORD: begin
        if (addr_lo[1:0] != 2'b00) err_c = 1'b1;
        else value_c = XLEN'(shifted);
      end
      default: err_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_result_buffer.sv
// Small FIFO of aligned load results waiting for the common data bus; head entry is
// presented from registers so a result pushed at one edge is on cdb_* right after it.
module load_result_buffer
  import sys_defs::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_done,
  input  logic [63:0]       load_data,
  input  logic [`XLEN-1:0]  load_addr,
  input  logic [2:0]        load_mem_size,
  input  logic [TAG_W-1:0]  load_tag,
  input  logic              squash,
  input  logic              cdb_grant,
  output logic              cdb_req,
  output logic [`XLEN-1:0]  cdb_value,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic              cdb_err,
  output logic              full,
  output logic              overflow
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam int unsigned      CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  lrb_entry_t       mem_q [DEPTH];
  lrb_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             cdb_req_q, cdb_req_d;
  logic [XLEN-1:0]  cdb_value_q, cdb_value_d;
  logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
  logic             cdb_err_q, cdb_err_d;
  logic             full_q, full_d;

  logic [XLEN-1:0]  align_value;
  logic             align_err;
  lrb_entry_t       new_ent;
  lrb_entry_t       head_ent;
  logic             push;
  logic             pop;
  logic             drop;

  load_align u_align (
    .load_data (load_data),
    .addr_lo   (load_addr[2:0]),
    .mem_size  (load_mem_size),
    .value_c   (align_value),
    .err_c     (align_err)
  );

  logic unused_addr_hi;
  assign unused_addr_hi = ^load_addr[`XLEN-1:3];

  // Queue bookkeeping, then the head entry as it will look after this edge.
  always_comb begin
    new_ent    = '{value: align_value, tag: TAG_W_MAX'(load_tag), err: align_err};
    pop        = (count_q != '0) && cdb_grant;
    push       = load_done && ((count_q != CNT_FULL) || pop);
    drop       = load_done && !push;
    mem_d      = mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (squash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = new_ent;
        tail_d        = tail_q + PTR_W'(1);
      end
      if (pop) head_d = head_q + PTR_W'(1);
      count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
      overflow_d = overflow_q | drop;
    end

    // The slot being written this cycle becomes head only when it lands on the new head.
    head_ent = '0;
    if (count_d != '0) head_ent = (push && (tail_q == head_d)) ? new_ent : mem_q[head_d];

    cdb_req_d   = (count_d != '0);
    cdb_value_d = head_ent.value;
    cdb_tag_d   = TAG_W'(head_ent.tag);
    cdb_err_d   = head_ent.err;
    full_d      = (count_d == CNT_FULL);
  end

  if (TAG_W < TAG_W_MAX) begin : g_tag_pad
    logic unused_tag_pad;
    assign unused_tag_pad = ^head_ent.tag[TAG_W_MAX-1:TAG_W];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      cdb_req_q   <= 1'b0;
      cdb_value_q <= '0;
      cdb_tag_q   <= '0;
      cdb_err_q   <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      cdb_req_q   <= cdb_req_d;
      cdb_value_q <= cdb_value_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_err_q   <= cdb_err_d;
      full_q      <= full_d;
    end
  end

  assign cdb_req   = cdb_req_q;
  assign cdb_value = cdb_value_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_err   = cdb_err_q;
  assign full      = full_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_load_result_buffer.sv
// Bench for load_result_buffer: directed scenarios plus a randomized run against a queue model.
`ifndef XLEN
`define XLEN 32
`endif

module tb_load_result_buffer;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned TAG_W = 5;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              load_done;
  logic [63:0]       load_data;
  logic [`XLEN-1:0]  load_addr;
  logic [2:0]        load_mem_size;
  logic [TAG_W-1:0]  load_tag;
  logic              squash;
  logic              cdb_grant;
  logic              cdb_req;
  logic [`XLEN-1:0]  cdb_value;
  logic [TAG_W-1:0]  cdb_tag;
  logic              cdb_err;
  logic              full;
  logic              overflow;

  always #5 clock = ~clock;

  load_result_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .load_done     (load_done),
    .load_data     (load_data),
    .load_addr     (load_addr),
    .load_mem_size (load_mem_size),
    .load_tag      (load_tag),
    .squash        (squash),
    .cdb_grant     (cdb_grant),
    .cdb_req       (cdb_req),
    .cdb_value     (cdb_value),
    .cdb_tag       (cdb_tag),
    .cdb_err       (cdb_err),
    .full          (full),
    .overflow      (overflow)
  );

  typedef struct {
    logic [31:0]      value;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t mq[$];
  bit   m_ovf;
  int   n_cmp;
  int   n_fail;

  localparam logic [63:0] VD [7] = '{64'h11223344_80556677, 64'h80012233_44556677,
                                     64'h11223344_80556677, 64'h11223344_80556677,
                                     64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D,
                                     64'h11223344_80556677};
  localparam logic [31:0] VA [7] = '{32'h1003, 32'h1006, 32'h1001, 32'h1003,
                                     32'h2004, 32'h2000, 32'h1002};
  localparam logic [2:0]  VS [7] = '{3'b000, 3'b101, 3'b010, 3'b100, 3'b010, 3'b011, 3'b001};
  localparam logic [31:0] VV [7] = '{32'hFFFFFF80, 32'h00008001, 32'h0, 32'h00000080,
                                     32'hDEADBEEF, 32'h0, 32'hFFFF8055};
  localparam logic        VE [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  // Expected result for one load, from byte counts and masks.
  function automatic exp_t ref_load(input logic [63:0] data, input logic [31:0] addr,
                                    input logic [2:0] size, input logic [TAG_W-1:0] tag);
    exp_t        e;
    int          nbytes;
    int          off;
    logic [63:0] raw;
    logic [63:0] mask;
    e.tag   = tag;
    e.value = '0;
    e.err   = 1'b0;
    off     = int'(addr[2:0]);
    case (size[1:0])
      2'b00:   nbytes = 1;
      2'b01:   nbytes = 2;
      2'b10:   nbytes = 4;
      default: nbytes = 0;
    endcase
    if (nbytes == 0 || (off % nbytes) != 0) begin
      e.err = 1'b1;
      return e;
    end
    mask = (64'd1 << (8 * nbytes)) - 64'd1;
    raw  = (data >> (8 * off)) & mask;
    if (!size[2] && nbytes < 4 && raw[8 * nbytes - 1]) raw = raw | ~mask;
    e.value = raw[31:0];
    return e;
  endfunction

  function automatic void model_step();
    bit was_full;
    bit pop;
    if (squash) begin
      mq.delete();
      return;
    end
    pop      = (mq.size() != 0) && cdb_grant;
    was_full = (mq.size() == DEPTH);
    if (pop) void'(mq.pop_front());
    if (load_done) begin
      if (was_full && !pop) m_ovf = 1'b1;
      else mq.push_back(ref_load(load_data, load_addr, load_mem_size, load_tag));
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    load_done     = 1'b0;
    load_data     = '0;
    load_addr     = '0;
    load_mem_size = 3'b010;
    load_tag      = '0;
    squash        = 1'b0;
    cdb_grant     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic push_word(input logic [TAG_W-1:0] tag);
    load_done     = 1'b1;
    load_data     = {$urandom, $urandom};
    load_addr     = 32'h4000;
    load_mem_size = 3'b010;
    load_tag      = tag;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 reset = 1'b0;
    #2;
    n_cmp += 6;
    if (cdb_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", cdb_req); end
    if (cdb_value !== '0) begin n_fail++; $display("FAIL reset_value: got %h want 0", cdb_value); end
    if (cdb_tag !== '0) begin n_fail++; $display("FAIL reset_tag: got %h want 0", cdb_tag); end
    if (cdb_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", cdb_err); end
    if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    push_word(5'd3);
    @(posedge clock);
    #1;
    n_cmp += 2;
    if (cdb_req !== 1'b0) begin n_fail++; $display("FAIL reset_hold_req: got %b want 0", cdb_req); end
    if (cdb_tag !== '0) begin n_fail++; $display("FAIL reset_hold_tag: got %h want 0", cdb_tag); end
    idle_inputs();
    reset = 1'b1;
  endtask

  task automatic test_align();
    do_reset();
    cdb_grant = 1'b1;
    for (int i = 0; i < 7; i++) begin
      load_done     = 1'b1;
      load_data     = VD[i];
      load_addr     = VA[i];
      load_mem_size = VS[i];
      load_tag      = TAG_W'(i + 1);
      tick();
      load_done = 1'b0;
      n_cmp += 4;
      if (cdb_req !== 1'b1) begin n_fail++; $display("FAIL align_req[%0d]: got %b want 1", i, cdb_req); end
      if (cdb_value !== VV[i]) begin n_fail++; $display("FAIL align_value[%0d]: got %h want %h", i, cdb_value, VV[i]); end
      if (cdb_err !== VE[i]) begin n_fail++; $display("FAIL align_err[%0d]: got %b want %b", i, cdb_err, VE[i]); end
      if (cdb_tag !== TAG_W'(i + 1)) begin n_fail++; $display("FAIL align_tag[%0d]: got %0d want %0d", i, cdb_tag, i + 1); end
      tick();
      n_cmp++;
      if (cdb_req !== 1'b0) begin n_fail++; $display("FAIL align_drain[%0d]: got %b want 0", i, cdb_req); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    push_word(5'd1);
    tick();
    n_cmp += 2;
    if (cdb_req !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL ovf_first: got req=%b full=%b want req=1 full=0", cdb_req, full); end
    if (cdb_tag !== 5'd1) begin n_fail++; $display("FAIL ovf_first_tag: got %0d want 1", cdb_tag); end
    push_word(5'd2);
    tick();
    n_cmp++;
    if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b want 1", full); end
    push_word(5'd3);
    tick();
    load_done = 1'b0;
    n_cmp += 2;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    if (cdb_tag !== 5'd1) begin n_fail++; $display("FAIL ovf_head: got %0d want 1", cdb_tag); end
    cdb_grant = 1'b1;
    tick();
    n_cmp += 2;
    if (cdb_tag !== 5'd2) begin n_fail++; $display("FAIL ovf_second: got %0d want 2", cdb_tag); end
    if (full !== 1'b0) begin n_fail++; $display("FAIL ovf_unfull: got %b want 0", full); end
    tick();
    n_cmp += 2;
    if (cdb_req !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b want 0", cdb_req); end
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_word(5'd4);
    tick();
    push_word(5'd5);
    tick();
    n_cmp++;
    if (full !== 1'b1) begin n_fail++; $display("FAIL b2b_full: got %b want 1", full); end
    push_word(5'd6);
    cdb_grant = 1'b1;
    tick();
    load_done = 1'b0;
    n_cmp += 3;
    if (full !== 1'b1) begin n_fail++; $display("FAIL b2b_still_full: got %b want 1", full); end
    if (cdb_tag !== 5'd5) begin n_fail++; $display("FAIL b2b_head: got %0d want 5", cdb_tag); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf: got %b want 0", overflow); end
    tick();
    n_cmp++;
    if (cdb_tag !== 5'd6 || full !== 1'b0) begin n_fail++; $display("FAIL b2b_tail: got tag=%0d full=%b want tag=6 full=0", cdb_tag, full); end
    tick();
    n_cmp++;
    if (cdb_req !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b want 0", cdb_req); end
  endtask

  task automatic test_squash();
    do_reset();
    push_word(5'd7);
    tick();
    push_word(5'd8);
    tick();
    push_word(5'd9);
    squash    = 1'b1;
    cdb_grant = 1'b1;
    tick();
    idle_inputs();
    n_cmp += 3;
    if (cdb_req !== 1'b0) begin n_fail++; $display("FAIL squash_req: got %b want 0", cdb_req); end
    if (full !== 1'b0) begin n_fail++; $display("FAIL squash_full: got %b want 0", full); end
    if (cdb_tag !== '0) begin n_fail++; $display("FAIL squash_tag: got %0d want 0", cdb_tag); end
    tick();
    n_cmp++;
    if (cdb_req !== 1'b0) begin n_fail++; $display("FAIL squash_stays_empty: got %b want 0", cdb_req); end
    push_word(5'd10);
    tick();
    push_word(5'd11);
    tick();
    load_done = 1'b0;
    n_cmp++;
    if (cdb_req !== 1'b1 || cdb_tag !== 5'd10) begin n_fail++; $display("FAIL squash_refill: got req=%b tag=%0d want req=1 tag=10", cdb_req, cdb_tag); end
    #2 reset = 1'b0;
    #1;
    n_cmp += 3;
    if (cdb_req !== 1'b0) begin n_fail++; $display("FAIL midrst_req: got %b want 0", cdb_req); end
    if (cdb_value !== '0 || cdb_tag !== '0) begin n_fail++; $display("FAIL midrst_data: got value=%h tag=%0d want 0", cdb_value, cdb_tag); end
    if (full !== 1'b0) begin n_fail++; $display("FAIL midrst_full: got %b want 0", full); end
    mq.delete();
    m_ovf = 1'b0;
    @(posedge clock);
    #1;
    reset     = 1'b1;
    cdb_grant = 1'b1;
    tick();
    n_cmp++;
    if (cdb_req !== 1'b0) begin n_fail++; $display("FAIL midrst_release: got %b want 0", cdb_req); end
  endtask

  task automatic test_random();
    exp_t e;
    bit   e_req;
    bit   e_full;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      load_done     = ($urandom_range(0, 9) < 6);
      load_data     = {$urandom, $urandom};
      load_addr     = $urandom;
      if ($urandom_range(0, 1) == 0) load_addr[1:0] = 2'b00;
      load_mem_size = 3'($urandom);
      load_tag      = TAG_W'($urandom);
      squash        = ($urandom_range(0, 19) == 0);
      cdb_grant     = ($urandom_range(0, 9) < 4);
      tick();
      e_req  = (mq.size() != 0);
      e_full = (mq.size() == DEPTH);
      e      = '{value: '0, tag: '0, err: 1'b0};
      if (e_req) e = mq[0];
      n_cmp += 6;
      if (cdb_req !== e_req) begin n_fail++; $display("FAIL rnd_req[%0d]: got %b want %b", c, cdb_req, e_req); end
      if (cdb_value !== e.value) begin n_fail++; $display("FAIL rnd_value[%0d]: got %h want %h", c, cdb_value, e.value); end
      if (cdb_tag !== e.tag) begin n_fail++; $display("FAIL rnd_tag[%0d]: got %0d want %0d", c, cdb_tag, e.tag); end
      if (cdb_err !== e.err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want %b", c, cdb_err, e.err); end
      if (full !== e_full) begin n_fail++; $display("FAIL rnd_full[%0d]: got %b want %b", c, full, e_full); end
      if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf[%0d]: got %b want %b", c, overflow, m_ovf); end
    end
    idle_inputs();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    m_ovf  = 1'b0;
    test_reset();
    test_align();
    test_overflow();
    test_back_to_back();
    test_squash();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/load_result_buffer.md
LOAD_RESULT_BUFFER -- requirements
Module: load_result_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of result entries (power of two, >=2).
REQ-002 SHALL have parameter TAG_W, default 5, destination-tag width.
REQ-003 SHALL have port clock  in  1  single system clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port load_done  in  1  load unit's data-cache return is valid this cycle.
REQ-006 SHALL have port load_data  in  64  raw doubleword returned by the data cache.
REQ-007 SHALL have port load_addr  in  `XLEN  effective byte address of the load.
REQ-008 SHALL have port load_mem_size  in  3  [1:0] 00 byte/01 half/10 word/11 reserved; [2]=1 unsigned.
REQ-009 SHALL have port load_tag  in  TAG_W  destination tag carried with the load.
REQ-010 SHALL have port squash  in  1  pipeline flush, discards all entries.
REQ-011 SHALL have port cdb_grant  in  1  broadcast bus accepts head entry this cycle.
REQ-012 SHALL have port cdb_req  out  1  head entry valid, requesting the broadcast bus.
REQ-013 SHALL have port cdb_value  out  `XLEN  aligned, extended load result of head entry.
REQ-014 SHALL have port cdb_tag  out  TAG_W  tag of head entry.
REQ-015 SHALL have port cdb_err  out  1  head entry is misaligned or reserved-size.
REQ-016 SHALL have port full  out  1  count==DEPTH; load unit holds its result while asserted.
REQ-017 SHALL have port overflow  out  1  sticky: load_done arrived while full and no pop.

Function
REQ-018 Extraction SHALL select bytes from load_data at offset load_addr[2:0] (little-endian).
REQ-019 Byte SHALL sign- or zero-extend bits [7:0] per load_mem_size[2]; half bits [15:0]; word bits [31:0], no extension.
REQ-020 Half with load_addr[0]=1, word with load_addr[1:0]!=0, or size 11 SHALL store value 0 and err=1.
REQ-021 Push SHALL occur on load_done when count<DEPTH, or when full and pop occurs in the same cycle.
REQ-022 Pop SHALL occur when cdb_req && cdb_grant; head advances next cycle.
REQ-023 Latency SHALL be one cycle: entry pushed at edge N is visible on cdb_* after edge N when buffer was empty.
REQ-024 cdb_req SHALL equal count!=0; cdb_value/tag/err SHALL be 0 when count==0.
REQ-025 Head/tail pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-026 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-027 Push when full without pop SHALL be dropped and set overflow until reset.
REQ-028 squash SHALL clear count and pointers at next edge, overriding same-cycle push and pop; overflow unaffected.
REQ-029 cdb_grant with cdb_req=0 SHALL be ignored.

Reset
REQ-030 reset low SHALL immediately clear count, pointers, overflow, and all entry valid state regardless of clock.
REQ-031 During and after reset: cdb_req=0, cdb_value=0, cdb_tag=0, cdb_err=0, full=0, overflow=0.
REQ-032 Reset mid-operation SHALL discard all entries; no partial entry SHALL be broadcast after release.

Structure
REQ-033 Entry struct (value, tag, err) and mem_size encodings SHALL live in the shared sys_defs package.
REQ-034 Extraction/extension SHALL be a combinational sub-module load_align.
REQ-035 Storage SHALL be a register array of DEPTH entries; no memory macro.

Verification
REQ-036 addr=0x1003, size=000, data byte3=0x80, grant held high -> cdb_value=0xFFFFFF80, err=0, one cycle after done.
REQ-037 addr=0x1006, size=101, data[63:48]=0x8001 -> cdb_value=0x00008001; addr=0x1001 size=010 -> value 0, err=1.
REQ-038 DEPTH=2, grant low, three consecutive done -> full after second, third dropped, overflow=1; grants then deliver tags 1,2 in order.
REQ-039 full buffer, done and grant same cycle -> count stays 2, new entry appended, head tag advances.
REQ-040 two entries held, squash with load_done same cycle -> next cycle cdb_req=0, count=0; reset low mid-stream -> outputs 0 immediately.
